// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg: shared VGA timing constants, region struct and colour-bar helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int COLOR_W_DEF  = 10;
  localparam int CNT_W_DEF    = 11;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int H_ACT_640    = 640;
  localparam int H_FRONT_640  = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BACK_640   = 48;
  localparam int V_ACT_480    = 480;
  localparam int V_FRONT_480  = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BACK_480   = 33;
  localparam int SYNC_POL_640 = 0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int H_ACT_800    = 800;
  localparam int H_FRONT_800  = 40;
  localparam int H_SYNC_800   = 128;
  localparam int H_BACK_800   = 88;
  localparam int V_ACT_600    = 600;
  localparam int V_FRONT_600  = 1;
  localparam int V_SYNC_600   = 4;
  localparam int V_BACK_600   = 23;
  localparam int SYNC_POL_800 = 1;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } vga_region_t;

  typedef logic [2:0] rgb_bits_t;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_bits_t bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter: h/v raster counters with wrap and region decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int H_ACT   = H_ACT_640,
  parameter int H_FRONT = H_FRONT_640,
  parameter int H_SYNC  = H_SYNC_640,
  parameter int H_BACK  = H_BACK_640,
  parameter int V_ACT   = V_ACT_480,
  parameter int V_FRONT = V_FRONT_480,
  parameter int V_SYNC  = V_SYNC_480,
  parameter int V_BACK  = V_BACK_480
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  output logic [CNT_W-1:0] oH,
  output logic [CNT_W-1:0] oV,
  output vga_region_t      oRegion
);

  localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_END_A = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_END_A = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACT + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACT + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACT + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (iEn) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    oRegion.active = (h_q < H_END_A) && (v_q < V_END_A);
    oRegion.hs     = (h_q >= HS_BEG) && (h_q < HS_END);
    oRegion.vs     = (v_q >= VS_BEG) && (v_q < VS_END);
    oRegion.first  = (h_q == '0) && (v_q == '0);
  end

  assign oH = h_q;
  assign oV = v_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen: VGA timing and registered DAC stage; VGA_TEST_PATTERN_EN adds colour bars
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int H_ACT   = H_ACT_640,
  parameter int H_FRONT = H_FRONT_640,
  parameter int H_SYNC  = H_SYNC_640,
  parameter int H_BACK  = H_BACK_640,
  parameter int V_ACT   = V_ACT_480,
  parameter int V_FRONT = V_FRONT_480,
  parameter int V_SYNC  = V_SYNC_480,
  parameter int V_BACK  = V_BACK_480,
  parameter int HS_POL  = SYNC_POL_640,
  parameter int VS_POL  = SYNC_POL_640
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               iPatSel,
`endif
  output logic               oReq,
  output logic [CNT_W-1:0]   oCurrX,
  output logic [CNT_W-1:0]   oCurrY,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oFrameStart,
  output logic [15:0]        oFrameCnt
);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [CNT_W-1:0] h, v;
  vga_region_t      region;

  vga_sync_counter #(
    .CNT_W  (CNT_W),
    .H_ACT  (H_ACT),
    .H_FRONT(H_FRONT),
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .V_ACT  (V_ACT),
    .V_FRONT(V_FRONT),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK)
  ) u_sync_counter (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .oH     (h),
    .oV     (v),
    .oRegion(region)
  );

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W+2:0] H_ACT_X = (CNT_W + 3)'(H_ACT);

  logic [CNT_W+2:0] h_x8;
  rgb_bits_t        bar;

  // Bar index h*8/H_ACT, only meaningful inside the active region
  always_comb begin
    h_x8 = {h, 3'b000};
    bar  = bar_rgb(3'(h_x8 / H_ACT_X));
  end

  always_comb begin
    pix_r = iRed;
    pix_g = iGreen;
    pix_b = iBlue;
    if (iPatSel) begin
      pix_r = {COLOR_W{bar[2]}};
      pix_g = {COLOR_W{bar[1]}};
      pix_b = {COLOR_W{bar[0]}};
    end
  end
`else
  always_comb begin
    pix_r = iRed;
    pix_g = iGreen;
    pix_b = iBlue;
  end
`endif

  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic               fs_q, fs_d;
  logic [15:0]        fcnt_q, fcnt_d;

  always_comb begin
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    fs_d    = fs_q;
    fcnt_d  = fcnt_q;
    if (iEn) begin
      r_d     = region.active ? pix_r : '0;
      g_d     = region.active ? pix_g : '0;
      b_d     = region.active ? pix_b : '0;
      hs_d    = region.hs ? HS_ON : ~HS_ON;
      vs_d    = region.vs ? VS_ON : ~VS_ON;
      blank_d = region.active;
      fs_d    = region.first;
      fcnt_d  = region.first ? fcnt_q + 16'd1 : fcnt_q;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oReq        = region.active & ~iRst;
  assign oCurrX      = oReq ? h : '0;
  assign oCurrY      = oReq ? v : '0;
  assign oVGA_R      = r_q;
  assign oVGA_G      = g_q;
  assign oVGA_B      = b_q;
  assign oVGA_HS     = hs_q;
  assign oVGA_VS     = vs_q;
  assign oVGA_BLANK  = blank_q;
  assign oVGA_SYNC   = 1'b1;
  // A pulse held across a stall reappears once counting resumes
  assign oFrameStart = fs_q & iEn;
  assign oFrameCnt   = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen: directed checks on a 640x480 instance and a tiny-raster instance
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  logic        clk;
  logic        rst, en;
  logic [9:0]  red, green, blue;
  logic        req, hs, vs, blank, sync, fs;
  logic [10:0] cx, cy;
  logic [9:0]  r, g, b;
  logic [15:0] fcnt;
  logic        patsel;

  logic        s_rst, s_en;
  logic [9:0]  s_col;
  logic        s_req, s_hs, s_vs, s_blank, s_sync, s_fs;
  logic [10:0] s_cx, s_cy;
  logic [9:0]  s_r, s_g, s_b;
  logic [15:0] s_fcnt;

  int n_total = 0;
  int n_bad   = 0;
  int k       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .iClk(clk), .iRst(rst), .iEn(en),
    .iRed(red), .iGreen(green), .iBlue(blue),
`ifdef VGA_TEST_PATTERN_EN
    .iPatSel(patsel),
`endif
    .oReq(req), .oCurrX(cx), .oCurrY(cy),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK(blank), .oVGA_SYNC(sync),
    .oFrameStart(fs), .oFrameCnt(fcnt)
  );

  // 16 x 8 raster, active-high HS, active-low VS: frame = 128 cycles
  vga_timing_gen #(
    .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1), .VS_POL(0)
  ) u_sml (
    .iClk(clk), .iRst(s_rst), .iEn(s_en),
    .iRed(s_col), .iGreen(s_col), .iBlue(s_col),
`ifdef VGA_TEST_PATTERN_EN
    .iPatSel(1'b0),
`endif
    .oReq(s_req), .oCurrX(s_cx), .oCurrY(s_cy),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK(s_blank), .oVGA_SYNC(s_sync),
    .oFrameStart(s_fs), .oFrameCnt(s_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Red marks only x=639; green carries the x coordinate so the DAC shows which pixel it holds
  task automatic drive();
    red   = (cx == 11'd639) ? 10'h3FF : 10'h000;
    green = cx[9:0];
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      drive();
      k++;
    end
  endtask

  task automatic adv(input int to);
    while (k < to) step(1);
  endtask

  int hits;
  int s_pulses;

  initial begin
    rst = 1'b1; en = 1'b1; red = '0; green = '0; blue = '0; patsel = 1'b0;
    s_rst = 1'b1; s_en = 1'b1; s_col = '0;
    step(3);

    chk("rst_req",   32'(req),   32'd0);
    chk("rst_cx",    32'(cx),    32'd0);
    chk("rst_r",     32'(r),     32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_hs",    32'(hs),    32'd1);
    chk("rst_vs",    32'(vs),    32'd1);
    chk("rst_fs",    32'(fs),    32'd0);
    chk("rst_fcnt",  32'(fcnt),  32'd0);
    chk("sync_tie",  32'(sync),  32'd1);

    @(negedge clk);
    rst = 1'b0;
    #1;
    drive();
    k = 0;
    chk("k0_req", 32'(req), 32'd1);
    chk("k0_xy",  {5'd0, cx, 5'd0, cy}, 32'd0);
    chk("k0_fs",  32'(fs),  32'd0);

    step(1);
    chk("k1_fs",    32'(fs),    32'd1);
    chk("k1_fcnt",  32'(fcnt),  32'd1);
    chk("k1_blank", 32'(blank), 32'd1);
    step(1);
    chk("k2_fs",    32'(fs),    32'd0);

    adv(639);
    chk("k639_cx", 32'(cx), 32'd639);
    chk("k639_r",  32'(r),  32'd0);
    adv(640);
    chk("k640_r",     32'(r),     32'h3FF);
    chk("k640_blank", 32'(blank), 32'd1);
    chk("k640_req",   32'(req),   32'd0);
    adv(641);
    chk("k641_r",     32'(r),     32'd0);
    chk("k641_blank", 32'(blank), 32'd0);
    chk("k641_g",     32'(g),     32'd0);

    adv(656);
    chk("hs_pre",   32'(hs), 32'd1);
    adv(657);
    chk("hs_first", 32'(hs), 32'd0);
    adv(752);
    chk("hs_last",  32'(hs), 32'd0);
    adv(753);
    chk("hs_end",   32'(hs), 32'd1);

    adv(800);
    hits = 0;
    while (k < 1600) begin
      step(1);
      if (r == 10'h3FF) hits++;
      if (k == 1456) chk("hs2_pre", 32'(hs), 32'd1);
      if (k == 1457) chk("hs2_on",  32'(hs), 32'd0);
      if (k == 1500) chk("porch_r", 32'(r),  32'd0);
    end
    chk("r_hits_line1", 32'(hits), 32'd1);
    chk("k1600_cy", 32'(cy), 32'd2);

    adv(1700);
    chk("pre_stall_cx", 32'(cx), 32'd100);
    chk("pre_stall_g",  32'(g),  32'd99);
    en = 1'b0;
    step(5);
    chk("stall_cx",   32'(cx),   32'd100);
    chk("stall_g",    32'(g),    32'd99);
    chk("stall_fs",   32'(fs),   32'd0);
    chk("stall_fcnt", 32'(fcnt), 32'd1);
    en = 1'b1;
    step(1);
    chk("resume_cx", 32'(cx), 32'd101);
    chk("resume_g",  32'(g),  32'd100);
    step(1);
    chk("resume2_g", 32'(g),  32'd101);

    step(198);
    chk("pre_rst_cx", 32'(cx), 32'd300);
    chk("pre_rst_cy", 32'(cy), 32'd2);
    chk("pre_rst_g",  32'(g),  32'd299);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(req),   32'd0);
    chk("arst_cx",    32'(cx),    32'd0);
    chk("arst_g",     32'(g),     32'd0);
    chk("arst_blank", 32'(blank), 32'd0);
    chk("arst_hs",    32'(hs),    32'd1);
    chk("arst_fcnt",  32'(fcnt),  32'd0);
    step(2);
`ifdef VGA_TEST_PATTERN_EN
    patsel = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    drive();
    k = 0;
    chk("rel_req", 32'(req), 32'd1);
    chk("rel_xy",  {5'd0, cx, 5'd0, cy}, 32'd0);
    step(1);
    chk("rel_fs",    32'(fs),    32'd1);
    chk("rel_fcnt",  32'(fcnt),  32'd1);
    chk("rel_blank", 32'(blank), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
    chk("pat_white",  {2'd0, r, g, b}, {2'd0, 10'h3FF, 10'h3FF, 10'h3FF});
    adv(81);
    chk("pat_yellow", {2'd0, r, g, b}, {2'd0, 10'h3FF, 10'h3FF, 10'h000});
    adv(241);
    chk("pat_green",  {2'd0, r, g, b}, {2'd0, 10'h000, 10'h3FF, 10'h000});
    adv(561);
    chk("pat_black",  {2'd0, r, g, b}, 32'd0);
`endif

    @(negedge clk);
    s_rst = 1'b0;
    #1;
    k = 0;
    s_pulses = 0;
    chk("s_rel_hs", 32'(s_hs), 32'd0);
    while (k < 256) begin
      step(1);
      if (s_fs) s_pulses++;
      if (k == 10)  chk("s_hs_k10",  32'(s_hs), 32'd0);
      if (k == 11)  chk("s_hs_k11",  32'(s_hs), 32'd1);
      if (k == 13)  chk("s_hs_k13",  32'(s_hs), 32'd1);
      if (k == 14)  chk("s_hs_k14",  32'(s_hs), 32'd0);
      if (k == 80)  chk("s_vs_k80",  32'(s_vs), 32'd1);
      if (k == 81)  chk("s_vs_k81",  32'(s_vs), 32'd0);
      if (k == 112) chk("s_vs_k112", 32'(s_vs), 32'd0);
      if (k == 113) chk("s_vs_k113", 32'(s_vs), 32'd1);
      if (k == 128) chk("s_fcnt_k128", {15'd0, s_fs, s_fcnt}, 32'h0000_0001);
      if (k == 129) chk("s_fcnt_k129", {15'd0, s_fs, s_fcnt}, 32'h0001_0002);
      if (k == 130) chk("s_fs_k130", 32'(s_fs), 32'd0);
    end
    chk("s_pulses", 32'(s_pulses), 32'd2);

    adv(293);
    chk("s_pre_rst_xy", {5'd0, s_cx, 5'd0, s_cy}, {5'd0, 11'd5, 5'd0, 11'd2});
    #2;
    s_rst = 1'b1;
    #1;
    chk("s_arst_cy",   32'(s_cy),   32'd0);
    chk("s_arst_req",  32'(s_req),  32'd0);
    chk("s_arst_fcnt", 32'(s_fcnt), 32'd0);
    chk("s_arst_hs",   32'(s_hs),   32'd0);
    chk("s_arst_vs",   32'(s_vs),   32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
